// File: rtl/serial_subtractor_8_bit.sv
// Bit-serial 8-bit subtractor: diff = x - y - borrow_in, LSB first, one bit per clock.
// Define SERIAL_SUB_OVERFLOW_EN to enable the registered signed-overflow flag.
module serial_subtractor_8_bit (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       borrow_in,
    output logic [7:0] diff,
    output logic       borrow_out,
    output logic       zero,
    output logic       overflow,
    output logic       busy,
    output logic       done
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t     state_q;
    logic [7:0] a_q, b_q, res_q, diff_q;
    logic       c_q, borrow_q, zero_q, busy_q, done_q;
    logic [2:0] cnt_q;

    logic       s_d, c_d;
    logic [7:0] res_d;

    // Subtraction as x + ~y + ~borrow_in through one full-adder cell.
    always_comb begin
        s_d   = a_q[0] ^ b_q[0] ^ c_q;
        c_d   = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
        res_d = {s_d, res_q[7:1]};
    end

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic xs_q, ys_q, ovf_q;
    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= 1'b0;
            cnt_q    <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            xs_q     <= 1'b0;
            ys_q     <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        a_q     <= x;
                        b_q     <= ~y;
                        c_q     <= ~borrow_in;
                        cnt_q   <= '0;
                        res_q   <= '0;
                        busy_q  <= 1'b1;
`ifdef SERIAL_SUB_OVERFLOW_EN
                        xs_q    <= x[7];
                        ys_q    <= y[7];
`endif
                    end
                end
                RUN: begin
                    a_q   <= {1'b0, a_q[7:1]};
                    b_q   <= {1'b0, b_q[7:1]};
                    c_q   <= c_d;
                    res_q <= res_d;
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_q  <= IDLE;
                        diff_q   <= res_d;
                        borrow_q <= ~c_d;
                        zero_q   <= (res_d == 8'h00);
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
`ifdef SERIAL_SUB_OVERFLOW_EN
                        ovf_q    <= (xs_q != ys_q) && (res_d[7] != xs_q);
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign diff       = diff_q;
    assign borrow_out = borrow_q;
    assign zero       = zero_q;
    assign busy       = busy_q;
    assign done       = done_q;
endmodule

// File: tb/tb_serial_subtractor_8_bit.sv
// Self-checking bench for serial_subtractor_8_bit: arithmetic reference model with
// per-cycle output comparison, directed cases and randomized start/operand traffic.
module tb_serial_subtractor_8_bit;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] x = '0, y = '0;
    logic       borrow_in = 1'b0;
    logic [7:0] diff;
    logic       borrow_out, zero, overflow, busy, done;

    int checks = 0;
    int errors = 0;
    int n_done = 0;

    serial_subtractor_8_bit dut (
        .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .borrow_in(borrow_in),
        .diff(diff), .borrow_out(borrow_out), .zero(zero), .overflow(overflow),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Reference model: result computed by plain integer arithmetic when the op is
    // accepted, published after eight further clock edges.
    logic       m_busy = 1'b0, m_done = 1'b0;
    int         m_rem = 0;
    logic [7:0] m_diff = '0, p_diff = '0;
    logic       m_bor = 1'b0, m_zero = 1'b0, m_ovf = 1'b0;
    logic       p_bor = 1'b0, p_zero = 1'b0, p_ovf = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_rem <= 0;
            m_diff <= '0; m_bor <= 1'b0; m_zero <= 1'b0; m_ovf <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_busy <= 1'b0; m_done <= 1'b1;
                    m_diff <= p_diff; m_bor <= p_bor; m_zero <= p_zero; m_ovf <= p_ovf;
                    n_done <= n_done + 1;
                end
            end else if (start) begin
                int full;
                logic [7:0] d8;
                full = int'(x) - int'(y) - int'(borrow_in);
                d8 = full[7:0];
                p_diff <= d8;
                p_bor  <= (full < 0);
                p_zero <= (d8 == 8'h00);
`ifdef SERIAL_SUB_OVERFLOW_EN
                p_ovf  <= (x[7] != y[7]) && (d8[7] != x[7]);
`else
                p_ovf  <= 1'b0;
`endif
                m_busy <= 1'b1;
                m_rem  <= 8;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle: whole output bundle against the model.
    always @(negedge clk) begin
        chk("cycle_outputs", {19'd0, busy, done, borrow_out, zero, overflow, diff},
            {19'd0, m_busy, m_done, m_bor, m_zero, m_ovf, m_diff});
    end

    // Launch one op from idle, wait (bounded) for done; returns at the negedge showing done.
    task automatic run_op(input logic [7:0] xa, input logic [7:0] ya, input logic ba,
                          output int busy_cycles);
        int k;
        x = xa; y = ya; borrow_in = ba; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        busy_cycles = 0;
        k = 0;
        @(negedge clk);
        while (!done && k < 20) begin
            if (busy) busy_cycles++;
            @(negedge clk);
            k++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    initial begin
        int bc;
        #12 rst = 1'b0;
        chk("reset_state", {26'd0, busy, done, borrow_out, zero, overflow, 1'b0} | {24'd0, diff}, 0);
        @(posedge clk); #1;

        run_op(8'd100, 8'd37, 1'b0, bc);
        chk("busy_len", bc, 8);
        chk("d100_37_diff", diff, 8'd63);
        chk("model_100_37", m_diff, 8'd63);
        chk("d100_37_flags", {borrow_out, zero, overflow, done}, 4'b0001);
        @(negedge clk);
        chk("done_one_cycle", done, 0);

        run_op(8'h05, 8'h09, 1'b0, bc);
        chk("d05_09", {borrow_out, zero, diff}, {2'b10, 8'hFC});
        chk("model_05_09", {m_bor, m_diff}, {1'b1, 8'hFC});

        run_op(8'h80, 8'h01, 1'b0, bc);
        chk("d80_01", {borrow_out, diff}, {1'b0, 8'h7F});
`ifdef SERIAL_SUB_OVERFLOW_EN
        chk("ovf_80_01", overflow, 1);
`else
        chk("ovf_80_01", overflow, 0);
`endif

        run_op(8'h3C, 8'h3C, 1'b0, bc);
        chk("d3c_3c", {zero, diff}, {1'b1, 8'h00});

        run_op(8'h00, 8'h00, 1'b1, bc);
        chk("d00_00_b1", {borrow_out, zero, diff}, {2'b10, 8'hFF});

        // Starts at T+3 and T+8 must be ignored.
        begin
            int dones0;
            dones0 = n_done;
            x = 8'h10; y = 8'h01; borrow_in = 1'b0; start = 1'b1;
            @(posedge clk); #1 start = 1'b0;             // T
            repeat (2) @(posedge clk);
            #1 begin x = 8'hAA; start = 1'b1; end        // sampled at T+3
            @(posedge clk); #1 start = 1'b0;
            repeat (4) @(posedge clk);
            #1 start = 1'b1;                             // sampled at T+8
            @(posedge clk); #1 start = 1'b0;
            chk("ign_diff", {done, diff}, {1'b1, 8'h0F});
            repeat (4) @(negedge clk);
            chk("ign_busy_low", busy, 0);
            chk("ign_single_done", n_done - dones0, 1);
        end

        // Asynchronous reset mid-operation.
        begin
            int dones0;
            x = 8'hF0; y = 8'h0F; borrow_in = 1'b0; start = 1'b1;
            @(posedge clk); #1 start = 1'b0;             // T
            repeat (4) @(posedge clk);
            #2 rst = 1'b1;
            #1 chk("rst_outputs", {busy, done, borrow_out, zero, overflow, diff}, 0);
            dones0 = n_done;
            repeat (3) @(posedge clk);
            #3 rst = 1'b0;
            repeat (10) @(negedge clk);
            chk("rst_no_done", n_done - dones0, 0);
            @(posedge clk); #1;
            run_op(8'h20, 8'h01, 1'b0, bc);
            chk("after_rst", diff, 8'h1F);
            chk("after_rst_len", bc, 8);
        end

        // Random traffic: start/operands toggle every cycle, including mid-RUN.
        begin
            int d0;
            d0 = n_done;
            for (int i = 0; i < 900; i++) begin
                @(posedge clk); #1;
                start = ($urandom_range(0, 2) == 0);
                x = 8'($urandom);
                y = 8'($urandom);
                borrow_in = 1'($urandom);
            end
            start = 1'b0;
            repeat (12) @(posedge clk);
            chk("rand_ops_seen", (n_done - d0 >= 50), 1);
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
